// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW forwarding (youngest stage wins) and stall unit with a long-latency write scoreboard; in: rf_raddr, byp_*, id_issue/id_long/id_waddr, lw_done/lw_waddr, flush; out: pause, fwd_occur, fwd_data, sb_busy, perf_stall_cnt (counter only when HZD_PERF_CNT_EN is defined)
module hazard_scoreboard #(
  parameter int NREAD    = 2,
  parameter int NSTAGE   = 3,
  parameter int MAX_LONG = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREAD*5-1:0]   rf_raddr,
  input  logic [NSTAGE-1:0]    byp_we,
  input  logic [NSTAGE*5-1:0]  byp_waddr,
  input  logic [NSTAGE-1:0]    byp_ready,
  input  logic [NSTAGE*32-1:0] byp_data,
  input  logic                 id_issue,
  input  logic                 id_long,
  input  logic [4:0]           id_waddr,
  input  logic                 lw_done,
  input  logic [4:0]           lw_waddr,
  input  logic                 flush,
  output logic                 pause,
  output logic [NREAD-1:0]     fwd_occur,
  output logic [NREAD*32-1:0]  fwd_data,
  output logic [31:0]          sb_busy,
  output logic [31:0]          perf_stall_cnt
);
  localparam int CW = $clog2(MAX_LONG + 1);
  logic [31:0] busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NREAD-1:0] rdy;
  logic sb_stall, set, clr;
  always_comb begin
    fwd_occur = '0;
    fwd_data = '0;
    rdy = '1;
    sb_stall = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      for (int s = NSTAGE - 1; s >= 0; s--)
        if (byp_we[s] && rf_raddr[5*i+:5] != 5'd0 && byp_waddr[5*s+:5] == rf_raddr[5*i+:5]) begin
          fwd_occur[i] = 1'b1;
          fwd_data[32*i+:32] = byp_data[32*s+:32];
          rdy[i] = byp_ready[s];
        end
      sb_stall = sb_stall | busy_q[rf_raddr[5*i+:5]];
    end
  end
  assign pause = |(fwd_occur & ~rdy) | sb_stall | (id_long & (busy_q[id_waddr] | cnt_q == CW'(MAX_LONG)));
  assign set = id_issue & id_long & (id_waddr != 5'd0);
  assign clr = lw_done & busy_q[lw_waddr];
  always_comb begin
    busy_d = flush ? '0 : (busy_q | (set ? 32'd1 << id_waddr : 32'd0)) & ~(clr ? 32'd1 << lw_waddr : 32'd0);
    cnt_d = flush ? '0
          : (set && !clr && cnt_q != CW'(MAX_LONG)) ? cnt_q + CW'(1)
          : (clr && !set && cnt_q != '0) ? cnt_q - CW'(1)
          : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  assign sb_busy = busy_q;
`ifdef HZD_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = (pause && perf_q != '1) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk) perf_q <= reset ? '0 : perf_d;
  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule
